// File: rtl/bellek_asamasi.sv
// Memory stage: data-memory request/response handshake, store lane masking, load extraction.
// Optional misaligned-access trap enabled by defining BELLEK_HIZALAMA_HATASI_EN.
`timescale 1ns/1ps
module bellek_asamasi #(
  parameter int ADRES_GENISLIGI = 32,
  parameter int VERI_GENISLIGI  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       durdur_i,
  input  logic [ADRES_GENISLIGI-1:0] bellek_adresi_i,
  input  logic [VERI_GENISLIGI-1:0]  bellek_veri_i,
  input  logic [2:0]                 load_save_buyrugu_i,
  input  logic                       bellekten_oku_i,
  input  logic                       bellege_yaz_i,
  input  logic [VERI_GENISLIGI-1:0]  hedef_yazmac_verisi_i,
  input  logic                       yazmaca_yaz_i,
  input  logic [4:0]                 hedef_yazmaci_i,
  output logic                       veri_bellek_istek_gecerli_o,
  input  logic                       veri_bellek_istek_hazir_i,
  output logic [ADRES_GENISLIGI-1:0] veri_bellek_adres_o,
  output logic                       veri_bellek_yaz_o,
  output logic [VERI_GENISLIGI-1:0]  veri_bellek_yaz_veri_o,
  output logic [3:0]                 veri_bellek_yaz_maske_o,
  input  logic [VERI_GENISLIGI-1:0]  veri_bellek_oku_veri_i,
  input  logic                       veri_bellek_oku_gecerli_i,
  output logic                       bellek_stall_o,
  output logic [VERI_GENISLIGI-1:0]  geri_yaz_verisi_o,
  output logic [4:0]                 geri_yaz_yazmaci_o,
  output logic                       geri_yaz_yazmaca_yaz_o,
  output logic                       hizalama_hatasi_o
);

  typedef enum logic [1:0] {
    BOSTA       = 2'b00,
    ISTEK       = 2'b01,
    YANIT_BEKLE = 2'b10,
    TAMAM       = 2'b11
  } durum_t;

  function automatic logic [3:0] maske_hesapla(input logic [2:0] tur, input logic [1:0] o);
    case (tur[1:0])
      2'b00:   return 4'b0001 << o;
      2'b01:   return o[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] yaz_veri_hesapla(input logic [2:0] tur, input logic [31:0] d);
    case (tur[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] yukleme_cikar(input logic [2:0] tur, input logic [1:0] o,
                                                input logic [31:0] w);
    logic [31:0] k;
    case (tur[1:0])
      2'b00:   k = w >> {o, 3'b000};
      2'b01:   k = w >> {o[1], 4'b0000};
      default: k = w;
    endcase
    case (tur[1:0])
      2'b00:   return tur[2] ? {24'h000000, k[7:0]} : {{24{k[7]}}, k[7:0]};
      2'b01:   return tur[2] ? {16'h0000, k[15:0]} : {{16{k[15]}}, k[15:0]};
      default: return k;
    endcase
  endfunction

  durum_t                       r_durum, w_sonraki;
  logic [ADRES_GENISLIGI-1:0]   r_adres;
  logic [2:0]                   r_tur;
  logic                         r_yaz, r_wen;
  logic [4:0]                   r_rd;
  logic [3:0]                   r_maske;
  logic [VERI_GENISLIGI-1:0]    r_yaz_veri, r_yuk, r_gy_veri;
  logic [4:0]                   r_gy_rd;
  logic                         r_gy_yaz, r_hiz;
  logic                         w_istek_var, w_hiz_hata, w_baslat, w_stall;

  assign w_istek_var = (r_durum == BOSTA) && !durdur_i && (bellekten_oku_i || bellege_yaz_i);

`ifdef BELLEK_HIZALAMA_HATASI_EN
  assign w_hiz_hata = w_istek_var &&
                      (((load_save_buyrugu_i[1:0] == 2'b01) && bellek_adresi_i[0]) ||
                       (load_save_buyrugu_i[1] && (bellek_adresi_i[1:0] != 2'b00)));
`else
  assign w_hiz_hata = 1'b0;
`endif

  // Reset is folded in so the stall cannot leak out while rst_i is held low.
  assign w_baslat = w_istek_var && !w_hiz_hata && rst_i;
  assign w_stall  = w_baslat || (r_durum == ISTEK) || (r_durum == YANIT_BEKLE);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_durum <= BOSTA;
    else        r_durum <= w_sonraki;
  end

  // Next-state logic; an accepted handshake always runs to completion regardless of durdur_i
  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      BOSTA:       if (w_baslat) w_sonraki = ISTEK; else w_sonraki = BOSTA;
      ISTEK:       if (veri_bellek_istek_hazir_i) w_sonraki = r_yaz ? TAMAM : YANIT_BEKLE;
                   else w_sonraki = ISTEK;
      YANIT_BEKLE: if (veri_bellek_oku_gecerli_i) w_sonraki = TAMAM; else w_sonraki = YANIT_BEKLE;
      TAMAM:       if (!durdur_i) w_sonraki = BOSTA; else w_sonraki = TAMAM;
      default:     w_sonraki = BOSTA;
    endcase
  end

  // Request latch at launch and load-data capture in YANIT_BEKLE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_adres <= '0; r_tur <= 3'b000; r_yaz <= 1'b0; r_wen <= 1'b0; r_rd <= 5'd0;
      r_maske <= 4'b0000; r_yaz_veri <= '0; r_yuk <= '0;
    end else begin
      if (w_baslat) begin
        r_adres    <= bellek_adresi_i;
        r_tur      <= load_save_buyrugu_i;
        r_yaz      <= bellege_yaz_i;
        r_wen      <= yazmaca_yaz_i;
        r_rd       <= hedef_yazmaci_i;
        r_maske    <= maske_hesapla(load_save_buyrugu_i, bellek_adresi_i[1:0]);
        r_yaz_veri <= yaz_veri_hesapla(load_save_buyrugu_i, bellek_veri_i);
      end
      if ((r_durum == YANIT_BEKLE) && veri_bellek_oku_gecerli_i)
        r_yuk <= yukleme_cikar(r_tur, r_adres[1:0], veri_bellek_oku_veri_i);
    end
  end

  // Write-back registers; frozen while durdur_i is high
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_gy_veri <= '0; r_gy_rd <= 5'd0; r_gy_yaz <= 1'b0; r_hiz <= 1'b0;
    end else if (!durdur_i) begin
      r_hiz <= 1'b0;
      if (w_stall) begin
        r_gy_yaz <= 1'b0;
      end else if (r_durum == TAMAM) begin
        if (r_yaz) begin
          r_gy_yaz <= 1'b0;
        end else begin
          r_gy_veri <= r_yuk;
          r_gy_rd   <= r_rd;
          r_gy_yaz  <= r_wen;
        end
      end else if (w_hiz_hata) begin
        r_gy_yaz <= 1'b0;
        r_hiz    <= 1'b1;
      end else begin
        r_gy_veri <= hedef_yazmac_verisi_i;
        r_gy_rd   <= hedef_yazmaci_i;
        r_gy_yaz  <= yazmaca_yaz_i;
      end
    end
  end

  assign veri_bellek_istek_gecerli_o = (r_durum == ISTEK);
  assign veri_bellek_adres_o         = {r_adres[ADRES_GENISLIGI-1:2], 2'b00};
  assign veri_bellek_yaz_o           = r_yaz;
  assign veri_bellek_yaz_veri_o      = r_yaz_veri;
  assign veri_bellek_yaz_maske_o     = r_maske;
  assign bellek_stall_o              = w_stall;
  assign geri_yaz_verisi_o           = r_gy_veri;
  assign geri_yaz_yazmaci_o          = r_gy_rd;
  assign geri_yaz_yazmaca_yaz_o      = r_gy_yaz;
  assign hizalama_hatasi_o           = r_hiz;

endmodule

// File: doc/bellek_asamasi.md
Name: bellek_asamasi

Overview:
- Memory stage, directly downstream of the execute stage. Consumes its address, store data, load/store type, destination register and result.
- Runs a valid/ready request plus read-response handshake with the data memory. Performs byte/half/word store masking and load extraction with sign or zero extension.
- Stalls the pipeline while an access is outstanding. Registers the final write-back value, destination register and write enable for the write-back stage.

Parameters:
- ADRES_GENISLIGI, 32, width of the data-memory address.
- VERI_GENISLIGI, 32, data width (the design covers 32 only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- durdur_i  in  1  global pipeline freeze
- bellek_adresi_i  in  32  effective address from execute
- bellek_veri_i  in  32  store data
- load_save_buyrugu_i  in  3  access type: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- bellekten_oku_i  in  1  load request
- bellege_yaz_i  in  1  store request
- hedef_yazmac_verisi_i  in  32  non-load result
- yazmaca_yaz_i  in  1  register write enable
- hedef_yazmaci_i  in  5  destination register
- veri_bellek_istek_gecerli_o  out  1  request valid
- veri_bellek_istek_hazir_i  in  1  memory accepts request
- veri_bellek_adres_o  out  32  word-aligned address {adr[31:2],2'b00}
- veri_bellek_yaz_o  out  1  1 = write, 0 = read
- veri_bellek_yaz_veri_o  out  32  lane-replicated store data
- veri_bellek_yaz_maske_o  out  4  byte enables
- veri_bellek_oku_veri_i  in  32  read data
- veri_bellek_oku_gecerli_i  in  1  read data valid
- bellek_stall_o  out  1  stall upstream
- geri_yaz_verisi_o  out  32  write-back data
- geri_yaz_yazmaci_o  out  5  write-back destination
- geri_yaz_yazmaca_yaz_o  out  1  write-back enable
- hizalama_hatasi_o  out  1  misaligned-access pulse (see Optional Feature)

Behaviour:
- Reset: rst_i low forces all outputs and registers to 0 and the FSM to BOSTA, asynchronously. An in-flight request is abandoned and gecerli_o drops immediately.
- FSM states: BOSTA, ISTEK, YANIT_BEKLE, TAMAM.
- BOSTA
  - If durdur_i=0 and (oku|yaz): latch address, type, data, rd and wen, then go to ISTEK. bellek_stall_o=1 combinationally in this same cycle.
  - If both oku and yaz are asserted, treat as a store.
- ISTEK
  - gecerli_o=1 with adres/yaz/veri/maske stable until hazir_i=1.
  - On hazir_i: store goes to TAMAM, load goes to YANIT_BEKLE.
- YANIT_BEKLE: wait for oku_gecerli_i, capture the extended load value, go to TAMAM. Read data arriving with gecerli_i in ISTEK's accept cycle is ignored.
- TAMAM: bellek_stall_o=0. If durdur_i=0, go to BOSTA unconditionally; the held instruction is never relaunched.
- bellek_stall_o = (BOSTA & (oku|yaz) & !durdur_i) | ISTEK | YANIT_BEKLE.
- durdur_i:
  - Blocks new launches from BOSTA.
  - An in-flight handshake continues to completion.
  - TAMAM and all write-back registers hold while durdur_i=1.
- Write-back registers update on every clock with durdur_i=0:
  - Stalled: geri_yaz_yazmaca_yaz_o <= 0 (bubble); data and rd hold.
  - BOSTA, no memory op: pass the inputs through (1-cycle latency).
  - TAMAM: load gives the captured load value; store gives yazmaca_yaz=0.
- Store masking: o = adr[1:0].
  - byte: maske = 0001<<o, veri = {4{d[7:0]}}.
  - half: maske = 0011<<(2*adr[1]), veri = {2{d[15:0]}}.
  - word: maske = 1111.
- Load extraction: shift read word right by 8*o (half uses adr[1] only), then sign-extend (000, 001) or zero-extend (100, 101).
- Codes 011, 110 and 111 behave as word.
- Latency, load with 0-wait memory: 4 clocks from acceptance in BOSTA to geri_yaz valid.

Optional Feature:
- Macro BELLEK_HIZALAMA_HATASI_EN.
- Defined: in BOSTA, a half access with adr[0]=1 or a word access with adr[1:0]!=0 issues no request and causes no stall. hizalama_hatasi_o pulses 1 for one cycle (registered with the write-back regs), and geri_yaz_yazmaca_yaz_o=0 for that instruction.
- Undefined: hizalama_hatasi_o is tied 0 and misaligned low bits are ignored per the masking rules.

Test Plan:
- sb adr=0x1003, d=0x000000AB, hazir_i=1 immediately -> maske=1000, veri=0xABABABAB, adres=0x1000, stall high for 2 cycles, geri_yaz_yazmaca_yaz_o=0.
- lh adr=0x2002, read data 0x8001_0000 one cycle after accept -> geri_yaz_verisi_o=0xFFFF8001. lhu same stimulus -> 0x00008001.
- add result 0x55, rd=7, no memory op -> next clock geri_yaz_verisi_o=0x55, yazmaci=7, yaz=1, stall never high.
- lw with hazir_i low for 3 cycles -> gecerli_o, adres and maske stable throughout, stall high until TAMAM, exactly one write-back pulse.
- rst_i low while in YANIT_BEKLE -> gecerli_o and stall drop asynchronously, outputs 0. After release, a new lw completes normally.
- Macro defined: lw adr=0x3001 -> hizalama_hatasi_o=1 for one cycle, no gecerli_o, yaz=0. Undefined: request issued to 0x3000.
